rpn_stack_controller: RTL and testbench

Upstream sequencer that evaluates a postfix (RPN) token stream on the team's 4-bit LIFO stack block. It accepts operand/operator tokens through a valid/ready handshake and drives the stack's Push/Pop/Data_In. It consumes the stack's Data_Out and Full/Empty, computes binary ALU results and pushes them back. On an '=' token it presents the popped top-of-stack as Result.

---
 rtl/rpn_stack_controller.sv | 206 ++++++++++++++++++++
 tb/tb_rpn_stack_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_controller.sv
// ============================================================================
//  Module   : rpn_stack_controller
//  Purpose  : Postfix (RPN) token sequencer driving an external LIFO stack.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rpn_stack_controller #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Tok_Valid,
  input  logic             Tok_Is_Op,
  input  logic [WIDTH-1:0] Tok_Data,
  output logic             Tok_Ready,
  output logic             Stk_Push,
  output logic             Stk_Pop,
  output logic [WIDTH-1:0] Stk_Data_In,
  input  logic [WIDTH-1:0] Stk_Data_Out,
  input  logic             Stk_Full,
  input  logic             Stk_Empty,
  output logic [WIDTH-1:0] Result,
  output logic             Result_Valid,
  output logic [1:0]       Error_Code
);

  localparam logic [3:0] c_IDLE  = 4'd0;
  localparam logic [3:0] c_PUSH  = 4'd1;
  localparam logic [3:0] c_POPB  = 4'd2;
  localparam logic [3:0] c_CAPB  = 4'd3;
  localparam logic [3:0] c_POPA  = 4'd4;
  localparam logic [3:0] c_CAPA  = 4'd5;
  localparam logic [3:0] c_PUSHR = 4'd6;
  localparam logic [3:0] c_POPEQ = 4'd7;
  localparam logic [3:0] c_CAPEQ = 4'd8;
  localparam logic [3:0] c_ERR   = 4'd9;

  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_SUB = 3'd1;
  localparam logic [2:0] c_OP_AND = 3'd2;
  localparam logic [2:0] c_OP_OR  = 3'd3;
  localparam logic [2:0] c_OP_XOR = 3'd4;
  localparam logic [2:0] c_OP_EQ  = 3'd5;

  localparam logic [1:0] c_ERR_NONE  = 2'd0;
  localparam logic [1:0] c_ERR_UNDER = 2'd1;
  localparam logic [1:0] c_ERR_OVER  = 2'd2;
  localparam logic [1:0] c_ERR_OPC   = 2'd3;

  logic [3:0]       state_q,  state_d;
  logic             ready_q,  ready_d;
  logic             push_q,   push_d;
  logic             pop_q,    pop_d;
  logic [WIDTH-1:0] din_q,    din_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rv_q,     rv_d;
  logic [1:0]       err_q,    err_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [2:0]       op_q,     op_d;

  function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      c_OP_ADD: r = a + b;
      c_OP_SUB: r = a - b;
      c_OP_AND: r = a & b;
      c_OP_OR:  r = a | b;
      c_OP_XOR: r = a ^ b;
      default:  r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    rv_d     = 1'b0;
    din_d    = din_q;
    result_d = result_q;
    err_d    = err_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;

    // Stack control is registered, so Empty/Full are judged one cycle
    // before the corresponding Push/Pop appears on the outputs.
    case (state_q)
      c_IDLE: begin
        if (Tok_Valid && ready_q) begin
          if (!Tok_Is_Op) begin
            if (Stk_Full) begin
              state_d = c_ERR;
              err_d   = c_ERR_OVER;
            end else begin
              state_d = c_PUSH;
              push_d  = 1'b1;
              din_d   = Tok_Data;
            end
          end else begin
            op_d = Tok_Data[2:0];
            case (Tok_Data[2:0])
              c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR: begin
                if (Stk_Empty) begin
                  state_d = c_ERR;
                  err_d   = c_ERR_UNDER;
                end else begin
                  state_d = c_POPB;
                  pop_d   = 1'b1;
                end
              end
              c_OP_EQ: begin
                if (Stk_Empty) begin
                  state_d = c_ERR;
                  err_d   = c_ERR_UNDER;
                end else begin
                  state_d = c_POPEQ;
                  pop_d   = 1'b1;
                end
              end
              default: begin
                state_d = c_ERR;
                err_d   = c_ERR_OPC;
              end
            endcase
          end
        end
      end
      c_PUSH:  state_d = c_IDLE;
      c_POPB:  state_d = c_CAPB;
      c_CAPB: begin
        b_d = Stk_Data_Out;
        if (Stk_Empty) begin
          state_d = c_ERR;
          err_d   = c_ERR_UNDER;
        end else begin
          state_d = c_POPA;
          pop_d   = 1'b1;
        end
      end
      c_POPA:  state_d = c_CAPA;
      c_CAPA: begin
        // A arrives this cycle; feed it straight into the ALU for the push.
        a_d     = Stk_Data_Out;
        din_d   = alu(op_q, Stk_Data_Out, b_q);
        push_d  = 1'b1;
        state_d = c_PUSHR;
      end
      c_PUSHR: state_d = c_IDLE;
      c_POPEQ: state_d = c_CAPEQ;
      c_CAPEQ: begin
        result_d = Stk_Data_Out;
        rv_d     = 1'b1;
        state_d  = c_IDLE;
      end
      c_ERR:   state_d = c_ERR;
      default: state_d = c_IDLE;
    endcase
  end

  assign ready_d = (state_d == c_IDLE);

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q  <= c_IDLE;
      ready_q  <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      din_q    <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      err_q    <= c_ERR_NONE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 3'd0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      din_q    <= din_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
    end
  end

  assign Tok_Ready    = ready_q;
  assign Stk_Push     = push_q;
  assign Stk_Pop      = pop_q;
  assign Stk_Data_In  = din_q;
  assign Result       = result_q;
  assign Result_Valid = rv_q;
  assign Error_Code   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rpn_stack_controller.sv
// ============================================================================
//  Module   : tb_rpn_stack_controller
//  Purpose  : Self-checking bench with an 8-deep LIFO stack and token model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rpn_stack_controller;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  logic             Clk = 1'b0;
  logic             RstN = 1'b0;
  logic             Tok_Valid = 1'b0;
  logic             Tok_Is_Op = 1'b0;
  logic [WIDTH-1:0] Tok_Data = '0;
  logic             Tok_Ready;
  logic             Stk_Push;
  logic             Stk_Pop;
  logic [WIDTH-1:0] Stk_Data_In;
  logic [WIDTH-1:0] Stk_Data_Out;
  logic             Stk_Full;
  logic             Stk_Empty;
  logic [WIDTH-1:0] Result;
  logic             Result_Valid;
  logic [1:0]       Error_Code;

  always #5 Clk = ~Clk;

  rpn_stack_controller #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .RstN(RstN),
    .Tok_Valid(Tok_Valid), .Tok_Is_Op(Tok_Is_Op), .Tok_Data(Tok_Data),
    .Tok_Ready(Tok_Ready),
    .Stk_Push(Stk_Push), .Stk_Pop(Stk_Pop), .Stk_Data_In(Stk_Data_In),
    .Stk_Data_Out(Stk_Data_Out), .Stk_Full(Stk_Full), .Stk_Empty(Stk_Empty),
    .Result(Result), .Result_Valid(Result_Valid), .Error_Code(Error_Code)
  );

  // LIFO stack the controller is meant to drive
  logic [WIDTH-1:0] mem [DEPTH];
  int sp;
  always @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      sp           <= 0;
      Stk_Data_Out <= '0;
    end else if (Stk_Push && sp < DEPTH) begin
      mem[sp] <= Stk_Data_In;
      sp      <= sp + 1;
    end else if (Stk_Pop && sp > 0) begin
      Stk_Data_Out <= mem[sp-1];
      sp           <= sp - 1;
    end
  end
  assign Stk_Empty = (sp == 0);
  assign Stk_Full  = (sp == DEPTH);

  int n_checks = 0;
  int n_fail   = 0;
  int n_push = 0, n_pop = 0, n_rv = 0, n_both = 0;
  int last_push = 0;

  always @(posedge Clk) begin
    if (RstN) begin
      if (Stk_Push) begin n_push++; last_push = int'(Stk_Data_In); end
      if (Stk_Pop) n_pop++;
      if (Result_Valid) n_rv++;
      if (Stk_Push && Stk_Pop) n_both++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit is_op;
    int data;
    int push_n;
    int push_val;
    int pops;
    int rv;
    int result;
    int err;
  } vec_t;

  function automatic vec_t mk(input bit o, input int d, input int pn, input int pv,
                              input int po, input int rv, input int res, input int er);
    vec_t v;
    v.is_op = o; v.data = d; v.push_n = pn; v.push_val = pv;
    v.pops = po; v.rv = rv; v.result = res; v.err = er;
    return v;
  endfunction

  // Reference model: plain postfix evaluator over a queue
  int mdl[$];
  int mdl_result = 0;

  function automatic vec_t model(input bit o, input int d);
    vec_t v;
    int a, b, r, op;
    v = mk(o, d, 0, 0, 0, 0, 0, 0);
    op = d % 8;
    if (!o) begin
      if (mdl.size() == DEPTH) v.err = 2;
      else begin mdl.push_back(d); v.push_n = 1; v.push_val = d; end
    end else if (op >= 6) begin
      v.err = 3;
    end else if (op == 5) begin
      if (mdl.size() == 0) v.err = 1;
      else begin mdl_result = mdl.pop_back(); v.pops = 1; v.rv = 1; end
    end else if (mdl.size() == 0) begin
      v.err = 1;
    end else if (mdl.size() == 1) begin
      void'(mdl.pop_back()); v.pops = 1; v.err = 1;
    end else begin
      b = mdl.pop_back();
      a = mdl.pop_back();
      case (op)
        0: r = (a + b) % 16;
        1: r = (a - b + 16) % 16;
        2: r = a & b;
        3: r = a | b;
        default: r = a ^ b;
      endcase
      mdl.push_back(r);
      v.pops = 2; v.push_n = 1; v.push_val = r;
    end
    v.result = mdl_result;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int p0, q0, r0, t;
    p0 = n_push; q0 = n_pop; r0 = n_rv;
    t = 0;
    while (!Tok_Ready && t < 20) begin @(negedge Clk); t++; end
    if (!Tok_Ready) begin chk({tag, "_ready_timeout"}, 0, 1); return; end
    Tok_Valid = 1'b1; Tok_Is_Op = v.is_op; Tok_Data = WIDTH'(v.data);
    @(posedge Clk); #1;
    Tok_Valid = 1'b0;
    @(negedge Clk);
    t = 0;
    while (!Tok_Ready && Error_Code == 2'd0 && t < 15) begin @(negedge Clk); t++; end
    if (!Tok_Ready && Error_Code == 2'd0) chk({tag, "_done_timeout"}, 0, 1);
    repeat (2) @(negedge Clk);
    chk({tag, "_push_n"}, n_push - p0, v.push_n);
    if (v.push_n == 1) chk({tag, "_push_val"}, last_push, v.push_val);
    chk({tag, "_pops"}, n_pop - q0, v.pops);
    chk({tag, "_rv"}, n_rv - r0, v.rv);
    chk({tag, "_result"}, int'(Result), v.result);
    chk({tag, "_err"}, int'(Error_Code), v.err);
    chk({tag, "_ready"}, int'(Tok_Ready), (v.err == 0) ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    RstN = 1'b0;
    #1;
    chk("rst_ready", int'(Tok_Ready), 0);
    chk("rst_push_pop", int'({Stk_Push, Stk_Pop}), 0);
    chk("rst_err", int'(Error_Code), 0);
    chk("rst_result", int'(Result), 0);
    repeat (2) @(negedge Clk);
    RstN = 1'b1;
    repeat (2) @(negedge Clk);
    mdl.delete();
    mdl_result = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  vec_t tbl[$];
  vec_t v;

  initial begin
    // directed table: operands, binary ops and EQ after a clean reset
    tbl.push_back(mk(0, 3,  1, 3,  0, 0, 0, 0));
    tbl.push_back(mk(0, 5,  1, 5,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0,  1, 8,  2, 0, 0, 0));
    tbl.push_back(mk(1, 5,  0, 0,  1, 1, 8, 0));
    tbl.push_back(mk(0, 2,  1, 2,  0, 0, 8, 0));
    tbl.push_back(mk(0, 5,  1, 5,  0, 0, 8, 0));
    tbl.push_back(mk(1, 1,  1, 13, 2, 0, 8, 0));
    tbl.push_back(mk(1, 5,  0, 0,  1, 1, 13, 0));
    tbl.push_back(mk(0, 12, 1, 12, 0, 0, 13, 0));
    tbl.push_back(mk(0, 10, 1, 10, 0, 0, 13, 0));
    tbl.push_back(mk(1, 2,  1, 8,  2, 0, 13, 0));
    tbl.push_back(mk(1, 5,  0, 0,  1, 1, 8, 0));
    tbl.push_back(mk(0, 12, 1, 12, 0, 0, 8, 0));
    tbl.push_back(mk(0, 10, 1, 10, 0, 0, 8, 0));
    tbl.push_back(mk(1, 4,  1, 6,  2, 0, 8, 0));
    tbl.push_back(mk(1, 5,  0, 0,  1, 1, 6, 0));
    tbl.push_back(mk(0, 7,  1, 7,  0, 0, 6, 0));
    tbl.push_back(mk(0, 9,  1, 9,  0, 0, 6, 0));
    tbl.push_back(mk(1, 11, 1, 15, 2, 0, 6, 0));
    tbl.push_back(mk(1, 13, 0, 0,  1, 1, 15, 0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
      if (i == 3) chk("empty_after_eq", int'(Stk_Empty), 1);
    end

    // binary operator on an empty stack
    do_reset();
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 1), "add_empty");

    // binary operator with one entry: single pop then underflow
    do_reset();
    run_vec(mk(0, 4, 1, 4, 0, 0, 0, 0), "one_opnd");
    run_vec(mk(1, 0, 0, 0, 1, 0, 0, 1), "add_one");

    // fill to Full, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) run_vec(mk(0, i + 3, 1, i + 3, 0, 0, 0, 0), "fill");
    chk("full_flag", int'(Stk_Full), 1);
    run_vec(mk(0, 9, 0, 0, 0, 0, 0, 2), "overflow");
    do_reset();
    chk("post_ovf_err", int'(Error_Code), 0);
    chk("post_ovf_ready", int'(Tok_Ready), 1);

    // invalid opcode
    run_vec(mk(1, 7, 0, 0, 0, 0, 0, 3), "bad_opc");

    // reset while the controller sits in CAPB
    do_reset();
    run_vec(mk(0, 9, 1, 9, 0, 0, 0, 0), "mid_a");
    run_vec(mk(0, 1, 1, 1, 0, 0, 0, 0), "mid_b");
    Tok_Valid = 1'b1; Tok_Is_Op = 1'b1; Tok_Data = 4'd0;
    @(posedge Clk); #1;
    Tok_Valid = 1'b0;
    @(posedge Clk); #2;
    RstN = 1'b0;
    #1;
    chk("mid_rst_outs", int'({Tok_Ready, Stk_Push, Stk_Pop, Result_Valid}), 0);
    chk("mid_rst_din", int'(Stk_Data_In), 0);
    chk("mid_rst_result", int'(Result), 0);
    chk("mid_rst_err", int'(Error_Code), 0);
    repeat (2) @(negedge Clk);
    RstN = 1'b1;
    repeat (2) @(negedge Clk);
    mdl.delete(); mdl_result = 0;
    chk("mid_rst_empty", int'(Stk_Empty), 1);
    run_vec(mk(0, 6, 1, 6, 0, 0, 0, 0), "post_mid_opnd");
    run_vec(mk(1, 5, 0, 0, 1, 1, 6, 0), "post_mid_eq");

    // randomized token stream against the reference model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)      v = model(0, $urandom_range(0, 15));
      else if (r < 85) v = model(1, $urandom_range(0, 4) + 8 * $urandom_range(0, 1));
      else if (r < 97) v = model(1, 5 + 8 * $urandom_range(0, 1));
      else             v = model(1, 6 + $urandom_range(0, 1) + 8 * $urandom_range(0, 1));
      run_vec(v, $sformatf("rnd%0d", i));
      if (v.err != 0) do_reset();
    end

    chk("push_pop_exclusive", n_both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
